// File: rtl/snn_io_pkg.sv
// Shared definitions for the SNN spike I/O sequencer.
// Contents:
//   seq_state_e  - sequencer FSM state encoding (2 bits)
//   OVF_CNT_W    - width of the saturating dropped-frame counter
//   DEF_*        - default parameter values used by the top level
//   sat_inc      - saturating increment for the dropped-frame counter
package snn_io_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        REPORT    = 2'd3
    } seq_state_e;

    localparam int OVF_CNT_W       = 8;

    localparam int DEF_N_IN        = 8;
    localparam int DEF_N_OUT       = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_OUT_PULSE   = 4;
    localparam int DEF_TIMEOUT     = 255;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == {OVF_CNT_W{1'b1}}) ? v : v + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spike_frame_fifo.sv
// Spike frame buffer: a DEPTH-entry FIFO, or a single holding slot that is
// overwritten by each new frame when fifo_mode is 0.
// Ports:
//   system_clock, sys_clk_reset - clock, asynchronous active-high reset
//   fifo_mode - 1 = FIFO of DEPTH frames, 0 = single-frame overwrite
//   push, wdata - frame write strobe and data
//   pop       - read request; honoured only when the registered count is non-zero
//   rdata     - head-of-queue frame
//   count     - occupancy, never exceeds DEPTH
//   drop      - one-cycle pulse when a frame is dropped (full) or overwritten
module spike_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     system_clock,
    input  logic                     sys_clk_reset,
    input  logic                     fifo_mode,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             pop_ok;
    logic             wr_ok;
    logic             ovw;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A same-cycle pop frees the slot a push into a full buffer needs; on an
    // empty buffer the pop is not honoured, so a push never bypasses storage.
    always_comb begin
        pop_ok = pop && !empty;
        wr_ok  = 1'b0;
        ovw    = 1'b0;
        drop   = 1'b0;
        if (push) begin
            if (fifo_mode) begin
                if (!full || pop_ok) begin
                    wr_ok = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                if (empty || pop_ok) begin
                    wr_ok = 1'b1;
                end else begin
                    ovw  = 1'b1;
                    drop = 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; occupancy tracking guarantees stale data is never read.
    always_ff @(posedge system_clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end else if (ovw) begin
            mem[rd_ptr] <= wdata;
        end
    end

    always_ff @(posedge system_clock or posedge sys_clk_reset) begin
        if (sys_clk_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   system_clock  - destination clock
//   sys_clk_reset - asynchronous active-high reset, clears the chain
//   async_in      - asynchronous input level
//   sync_out      - input level after STAGES flops
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic system_clock,
    input  logic sys_clk_reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge system_clock or posedge sys_clk_reset) begin
        if (sys_clk_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/snn_spike_io_sequencer.sv
// SNN spike I/O sequencer: synchronises the pad strobes, buffers input spike
// frames, issues one SNN step per frame, waits for completion (with timeout)
// and reports the captured output spikes with a stretched output_ready.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for snn_en and a buffered frame
//   ISSUE     | snn_step high for one cycle, frame on snn_spikes
//   WAIT_DONE | waiting for snn_done; timer counts down to timeout
//   REPORT    | output_ready high for OUT_PULSE cycles
//
// Ports:
//   system_clock, sys_clk_reset    - clock, asynchronous active-high reset
//   input_ready, input_spikes      - async frame strobe and frame data
//   snn_en                         - async SNN enable
//   fifo_mode                      - 1 = FIFO, 0 = single-frame overwrite
//   snn_spikes, snn_step           - frame and step request to the core
//   snn_done, snn_out_spikes       - completion pulse and result from the core
//   out_spikes, output_ready       - captured result and its stretched strobe
//   timeout_flag                   - sticky step-timeout indicator
//   fifo_count, overflow_cnt, busy - status
module snn_spike_io_sequencer
    import snn_io_pkg::*;
#(
    parameter int N_IN        = DEF_N_IN,
    parameter int N_OUT       = DEF_N_OUT,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int OUT_PULSE   = DEF_OUT_PULSE,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   system_clock,
    input  logic                   sys_clk_reset,
    input  logic                   input_ready,
    input  logic [N_IN-1:0]        input_spikes,
    input  logic                   snn_en,
    input  logic                   fifo_mode,
    output logic [N_IN-1:0]        snn_spikes,
    output logic                   snn_step,
    input  logic                   snn_done,
    input  logic [N_OUT-1:0]       snn_out_spikes,
    output logic [N_OUT-1:0]       out_spikes,
    output logic                   output_ready,
    output logic                   timeout_flag,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [OVF_CNT_W-1:0]   overflow_cnt,
    output logic                   busy
);

    localparam int   TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int   PULSE_W    = (OUT_PULSE > 1) ? $clog2(OUT_PULSE) : 1;
    localparam bit   TMO_EN     = (TIMEOUT != 0);
    // Down-counters are loaded with N-1 and expire on the cycle they read zero.
    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(OUT_PULSE - 1);

    seq_state_e         state;
    logic [TMR_W-1:0]   tmr;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               ir_sync;
    logic               ir_prev;
    logic               en_sync;
    logic               frame_push;
    logic               frame_pop;
    logic               frame_drop;
    logic [N_IN-1:0]    head_frame;

    synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ready (
        .system_clock  (system_clock),
        .sys_clk_reset (sys_clk_reset),
        .async_in      (input_ready),
        .sync_out      (ir_sync)
    );

    synchronizer #(.STAGES(SYNC_STAGES)) u_sync_en (
        .system_clock  (system_clock),
        .sys_clk_reset (sys_clk_reset),
        .async_in      (snn_en),
        .sync_out      (en_sync)
    );

    always_ff @(posedge system_clock or posedge sys_clk_reset) begin
        if (sys_clk_reset) begin
            ir_prev <= 1'b0;
        end else begin
            ir_prev <= ir_sync;
        end
    end

    assign frame_push = ir_sync && !ir_prev;
    assign frame_pop  = (state == IDLE) && en_sync && (fifo_count != '0);

    spike_frame_fifo #(.WIDTH(N_IN), .DEPTH(DEPTH)) u_fifo (
        .system_clock  (system_clock),
        .sys_clk_reset (sys_clk_reset),
        .fifo_mode     (fifo_mode),
        .push          (frame_push),
        .wdata         (input_spikes),
        .pop           (frame_pop),
        .rdata         (head_frame),
        .count         (fifo_count),
        .drop          (frame_drop)
    );

    always_ff @(posedge system_clock or posedge sys_clk_reset) begin
        if (sys_clk_reset) begin
            overflow_cnt <= '0;
        end else if (frame_drop) begin
            overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

    always_ff @(posedge system_clock or posedge sys_clk_reset) begin
        if (sys_clk_reset) begin
            state        <= IDLE;
            snn_spikes   <= '0;
            snn_step     <= 1'b0;
            out_spikes   <= '0;
            output_ready <= 1'b0;
            timeout_flag <= 1'b0;
            tmr          <= '0;
            pulse_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_pop) begin
                        snn_spikes <= head_frame;
                        snn_step   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    snn_step <= 1'b0;
                    tmr      <= TMR_LOAD;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Completion wins over a timeout expiring in the same cycle.
                    if (snn_done) begin
                        out_spikes   <= snn_out_spikes;
                        output_ready <= 1'b1;
                        pulse_cnt    <= PULSE_LOAD;
                        state        <= REPORT;
                    end else if (TMO_EN && (tmr == '0)) begin
                        out_spikes   <= '0;
                        timeout_flag <= 1'b1;
                        output_ready <= 1'b1;
                        pulse_cnt    <= PULSE_LOAD;
                        state        <= REPORT;
                    end else if (tmr != '0) begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                REPORT: begin
                    if (pulse_cnt == '0) begin
                        output_ready <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - PULSE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_snn_spike_io_sequencer.sv
module tb_snn_spike_io_sequencer;

    localparam int N_IN      = 8;
    localparam int N_OUT     = 8;
    localparam int DEPTH     = 4;
    localparam int SYNC      = 2;
    localparam int PULSE     = 4;
    localparam int TMO       = 10;

    logic             system_clock;
    logic             sys_clk_reset;
    logic             input_ready;
    logic [N_IN-1:0]  input_spikes;
    logic             snn_en;
    logic             fifo_mode;
    logic [N_IN-1:0]  snn_spikes;
    logic             snn_step;
    logic             snn_done;
    logic [N_OUT-1:0] snn_out_spikes;
    logic [N_OUT-1:0] out_spikes;
    logic             output_ready;
    logic             timeout_flag;
    logic [2:0]       fifo_count;
    logic [7:0]       overflow_cnt;
    logic             busy;

    logic             core_done;
    logic [N_OUT-1:0] core_out;
    logic             spur_done;
    logic [N_OUT-1:0] spur_out;

    assign snn_done       = core_done | spur_done;
    assign snn_out_spikes = spur_done ? spur_out : core_out;

    snn_spike_io_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .SYNC_STAGES(SYNC),
        .OUT_PULSE(PULSE), .TIMEOUT(TMO)
    ) dut (
        .system_clock   (system_clock),
        .sys_clk_reset  (sys_clk_reset),
        .input_ready    (input_ready),
        .input_spikes   (input_spikes),
        .snn_en         (snn_en),
        .fifo_mode      (fifo_mode),
        .snn_spikes     (snn_spikes),
        .snn_step       (snn_step),
        .snn_done       (snn_done),
        .snn_out_spikes (snn_out_spikes),
        .out_spikes     (out_spikes),
        .output_ready   (output_ready),
        .timeout_flag   (timeout_flag),
        .fifo_count     (fifo_count),
        .overflow_cnt   (overflow_cnt),
        .busy           (busy)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: queue of pending frames, saturating drop count,
    // sticky timeout, and the expected result of each issued step.
    typedef struct {
        logic [7:0] val;
        bit         tmo;
        int         step_cyc;
        int         lat;
    } res_t;

    logic [7:0] m_q[$];
    int         m_ovf    = 0;
    bit         m_tflag  = 0;
    res_t       r_q[$];
    int         n_steps  = 0;
    int         n_reports = 0;
    bit         core_hang = 0;
    bit         core_fixed = 0;
    logic [7:0] core_fixed_val = 8'h00;
    bit         in_reset = 0;
    bit         step_prev = 0;
    bit         or_prev = 0;
    int         or_high = 0;
    res_t       ce_r;
    int         ce_d;
    res_t       rm_r;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] v, input bit fmode);
        if (fmode) begin
            if (m_q.size() < DEPTH) m_q.push_back(v);
            else if (m_ovf < 255) m_ovf++;
        end else begin
            if (m_q.size() == 0) m_q.push_back(v);
            else begin
                m_q[0] = v;
                if (m_ovf < 255) m_ovf++;
            end
        end
    endfunction

    initial forever begin
        @(posedge system_clock);
        cyc = cyc + 1;
    end

    // Step monitor: one-cycle pulse, frame must be the model's head frame.
    initial forever begin
        @(negedge system_clock);
        if (step_prev) check_val("step_width", {31'b0, snn_step}, 0);
        if (snn_step && !step_prev) begin
            n_steps++;
            check_val("step_frame_avail", {31'b0, m_q.size() > 0}, 1);
            if (m_q.size() > 0) check_val("step_frame", {24'b0, snn_spikes}, {24'b0, m_q.pop_front()});
        end
        step_prev = snn_step;
    end

    // Behavioural SNN core: answers each step after 1..5 cycles, or never.
    initial begin
        core_done = 1'b0;
        core_out  = '0;
        forever begin
            @(negedge system_clock);
            if (snn_step && !in_reset) begin
                ce_r.step_cyc = cyc;
                if (core_hang) begin
                    ce_r.val = 8'h00;
                    ce_r.tmo = 1'b1;
                    ce_r.lat = TMO + 1;
                    r_q.push_back(ce_r);
                end else begin
                    ce_d     = $urandom_range(1, 5);
                    ce_r.val = core_fixed ? core_fixed_val : 8'($urandom);
                    ce_r.tmo = 1'b0;
                    ce_r.lat = ce_d + 1;
                    r_q.push_back(ce_r);
                    repeat (ce_d) @(negedge system_clock);
                    core_out  = ce_r.val;
                    core_done = 1'b1;
                    @(negedge system_clock);
                    core_done = 1'b0;
                    core_out  = 8'($urandom);
                end
            end
        end
    end

    // Report monitor: result value, latency from step, flag, pulse width.
    initial forever begin
        @(negedge system_clock);
        if (output_ready && !or_prev) begin
            n_reports++;
            check_val("report_pending", {31'b0, r_q.size() > 0}, 1);
            if (r_q.size() > 0) begin
                rm_r = r_q.pop_front();
                if (rm_r.tmo) m_tflag = 1'b1;
                check_val("out_spikes", {24'b0, out_spikes}, {24'b0, rm_r.val});
                check_val("report_latency", cyc - rm_r.step_cyc, rm_r.lat);
                check_val("timeout_flag", {31'b0, timeout_flag}, {31'b0, m_tflag});
            end
            or_high = 0;
        end
        if (output_ready) or_high++;
        if (!output_ready && or_prev && !in_reset) check_val("output_ready_width", or_high, PULSE);
        or_prev = output_ready;
    end

    task automatic check_all_zero(input string p);
        check_val({p, "_snn_spikes"},   {24'b0, snn_spikes},   0);
        check_val({p, "_snn_step"},     {31'b0, snn_step},     0);
        check_val({p, "_out_spikes"},   {24'b0, out_spikes},   0);
        check_val({p, "_output_ready"}, {31'b0, output_ready}, 0);
        check_val({p, "_timeout_flag"}, {31'b0, timeout_flag}, 0);
        check_val({p, "_fifo_count"},   {29'b0, fifo_count},   0);
        check_val({p, "_overflow_cnt"}, {24'b0, overflow_cnt}, 0);
        check_val({p, "_busy"},         {31'b0, busy},         0);
    endtask

    task automatic do_reset();
        in_reset      = 1'b1;
        sys_clk_reset = 1'b1;
        repeat (3) @(negedge system_clock);
        m_q.delete();
        r_q.delete();
        m_ovf   = 0;
        m_tflag = 1'b0;
        sys_clk_reset = 1'b0;
        in_reset      = 1'b0;
        @(negedge system_clock);
    endtask

    task automatic set_en(input logic v);
        snn_en = v;
        repeat (SYNC + 2) @(negedge system_clock);
    endtask

    task automatic push_frame(input logic [7:0] v);
        @(negedge system_clock);
        input_spikes = v;
        @(negedge system_clock);
        input_ready = 1'b1;
        model_push(v, fifo_mode);
        repeat (SYNC + 3) @(negedge system_clock);
        input_ready = 1'b0;
        repeat (SYNC + 1) @(negedge system_clock);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while (!(m_q.size() == 0 && r_q.size() == 0 && !busy && !output_ready && fifo_count == 0)
               && n < budget) begin
            @(negedge system_clock);
            n++;
        end
        check_val({tag, "_drain_in_time"}, {31'b0, n < budget}, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || output_ready) && n < budget) begin
            @(negedge system_clock);
            n++;
        end
        check_val({tag, "_idle_in_time"}, {31'b0, n < budget}, 1);
    endtask

    task automatic wait_step(input string tag, input int budget);
        int n0 = n_steps;
        int n  = 0;
        while (n_steps == n0 && n < budget) begin
            @(negedge system_clock);
            n++;
        end
        check_val({tag, "_step_in_time"}, {31'b0, n < budget}, 1);
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_fifo_count"},   {29'b0, fifo_count},   m_q.size());
        check_val({tag, "_overflow_cnt"}, {24'b0, overflow_cnt}, m_ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int k;
        sys_clk_reset = 1'b1;
        input_ready   = 1'b0;
        input_spikes  = '0;
        snn_en        = 1'b0;
        fifo_mode     = 1'b1;
        spur_done     = 1'b0;
        spur_out      = '0;
        #2;
        check_all_zero("rst");
        repeat (2) @(negedge system_clock);
        sys_clk_reset = 1'b0;
        @(negedge system_clock);

        // FIFO path: single frame, fixed core result
        fifo_mode      = 1'b1;
        set_en(1'b1);
        core_fixed     = 1'b1;
        core_fixed_val = 8'h3C;
        push_frame(8'hA5);
        wait_drained("t1", 200);
        check_val("t1_out_spikes", {24'b0, out_spikes}, 32'h3C);
        check_val("t1_steps", n_steps, 1);
        check_val("t1_reports", n_reports, 1);
        core_fixed = 1'b0;

        // Spurious completion in IDLE is ignored
        r0 = n_reports;
        @(negedge system_clock);
        spur_out  = 8'hFF;
        spur_done = 1'b1;
        @(negedge system_clock);
        spur_done = 1'b0;
        repeat (10) @(negedge system_clock);
        check_val("spur_out_spikes", {24'b0, out_spikes}, 32'h3C);
        check_val("spur_reports", n_reports, r0);
        check_val("spur_busy", {31'b0, busy}, 0);

        // Overflow in FIFO mode, then ordered drain
        set_en(1'b0);
        for (int i = 1; i <= 6; i++) push_frame(8'(i));
        check_status("t2");
        s0 = n_steps;
        set_en(1'b1);
        wait_drained("t2", 500);
        check_val("t2_steps", n_steps - s0, DEPTH);

        // Overwrite mode
        set_en(1'b0);
        do_reset();
        fifo_mode = 1'b0;
        push_frame(8'h11);
        push_frame(8'h22);
        push_frame(8'h33);
        check_status("t3");
        s0 = n_steps;
        set_en(1'b1);
        wait_drained("t3", 300);
        check_val("t3_steps", n_steps - s0, 1);

        // Timeout
        fifo_mode = 1'b1;
        core_hang = 1'b1;
        push_frame(8'h5A);
        wait_drained("t4", 300);
        check_val("t4_out_spikes", {24'b0, out_spikes}, 0);
        check_val("t4_timeout_flag", {31'b0, timeout_flag}, 1);
        core_hang = 1'b0;
        repeat (5) @(negedge system_clock);
        check_val("t4_flag_sticky", {31'b0, timeout_flag}, 1);

        // snn_en dropped mid-step: step completes, queue retained
        set_en(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) push_frame(8'($urandom));
        s0 = n_steps;
        snn_en = 1'b1;
        wait_step("t5", 100);
        snn_en = 1'b0;
        wait_idle("t5", 100);
        repeat (10) @(negedge system_clock);
        check_val("t5_steps", n_steps - s0, 1);
        check_val("t5_fifo_count", {29'b0, fifo_count}, m_q.size());
        check_val("t5_busy", {31'b0, busy}, 0);

        // Reset while in WAIT_DONE
        core_hang = 1'b1;
        snn_en    = 1'b1;
        wait_step("t5r", 100);
        repeat (3) @(negedge system_clock);
        check_val("t5r_busy_before", {31'b0, busy}, 1);
        #2;
        in_reset      = 1'b1;
        sys_clk_reset = 1'b1;
        #1;
        check_all_zero("midrst");
        snn_en = 1'b0;
        do_reset();
        core_hang = 1'b0;
        repeat (SYNC + 2) @(negedge system_clock);
        check_val("t5r_fifo_after", {29'b0, fifo_count}, 0);

        // Saturation of the drop counter: 4 stored + 300 dropped
        fifo_mode = 1'b1;
        for (int i = 0; i < DEPTH + 300; i++) push_frame(8'($urandom));
        check_status("t6");
        set_en(1'b1);
        wait_drained("t6", 500);

        // Randomized bursts against the model
        for (int it = 0; it < 8; it++) begin
            set_en(1'b0);
            fifo_mode = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 7);
            for (int i = 0; i < k; i++) push_frame(8'($urandom));
            check_status("rnd");
            core_hang = ($urandom_range(0, 5) == 0);
            set_en(1'b1);
            wait_drained("rnd", 800);
            core_hang = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_spike_io_sequencer.md
Name: snn_spike_io_sequencer

Overview:
- Parametrised successor of the fixed 8-bit input_spikes capture register and output_ready logic in the SNN top level.
- Synchronises the asynchronous input_ready and SNN_en pins.
- Buffers input spike frames in a FIFO, or holds one frame in single-frame overwrite mode.
- Issues one SNN step per frame, waits for completion with a timeout, then captures the output spikes and raises a stretched output_ready.

Parameters:
- N_IN, 8: input spike channels (frame width).
- N_OUT, 8: output spike channels.
- DEPTH, 4: FIFO depth in frames, power of 2, ≥2.
- SYNC_STAGES, 2: flops per synchroniser, ≥2.
- OUT_PULSE, 4: output_ready high time in cycles, ≥1.
- TIMEOUT, 255: maximum cycles in WAIT_DONE; 0 disables the timeout.

Ports:
- system_clock  in  1  system clock
- sys_clk_reset  in  1  reset, asynchronous, active-high
- input_ready  in  1  asynchronous frame strobe from the pad
- input_spikes  in  N_IN  frame data; stable from ≥1 cycle before input_ready rises until SYNC_STAGES+2 cycles after
- snn_en  in  1  asynchronous SNN enable from the pad
- fifo_mode  in  1  1 = FIFO of DEPTH frames, 0 = single-frame overwrite; quasi-static, change only while idle
- snn_spikes  out  N_IN  frame presented to the SNN core
- snn_step  out  1  one-cycle step request to the SNN core
- snn_done  in  1  synchronous completion pulse from the core (output_data_ready)
- snn_out_spikes  in  N_OUT  core output spikes, valid while snn_done=1
- out_spikes  out  N_OUT  captured result, registered
- output_ready  out  1  high for OUT_PULSE cycles per completed step
- timeout_flag  out  1  sticky; set on step timeout, cleared by reset
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overflow_cnt  out  8  dropped or overwritten frames, saturates at 255
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, synchronisers cleared.
- Input sync: input_ready passes through SYNC_STAGES flops, then a rising-edge detector. The detected edge writes input_spikes SYNC_STAGES+1 cycles after the pin rise. Same treatment for snn_en, without the edge detector.
- Push, fifo_mode=1:
  - Frame is written if not full.
  - If full, the frame is dropped and overflow_cnt increments.
  - If full with a pop in the same cycle, the push is accepted.
- Push, fifo_mode=0:
  - Holding slot of depth 1.
  - If the slot is occupied, the new frame overwrites it and overflow_cnt increments. fifo_count stays 1.
- Pop: uses registered occupancy only. Push and pop together on an empty FIFO: push only, pop waits for the next cycle.
- FSM states IDLE, ISSUE, WAIT_DONE, REPORT:
  - IDLE → ISSUE when snn_en_sync=1 and fifo_count>0. The frame is popped into the snn_spikes register on this transition.
  - ISSUE: snn_step=1 for exactly one cycle. Next state is WAIT_DONE. snn_spikes stays stable until the next ISSUE.
  - WAIT_DONE → REPORT on snn_done. snn_out_spikes is captured into out_spikes on the same edge.
  - WAIT_DONE timeout: after TIMEOUT cycles without snn_done, go to REPORT. out_spikes is set to 0 and timeout_flag is set.
  - REPORT: output_ready high for OUT_PULSE cycles, then IDLE. Minimum frame-to-frame period is 3+OUT_PULSE cycles.
- snn_done outside WAIT_DONE is ignored.
- snn_en deasserted mid-step: the current step completes normally. The FSM then stays IDLE and FIFO contents are retained.
- Reset mid-operation: immediate return to reset state. Buffered frames are discarded.
- Counter widths: fifo_count never exceeds DEPTH. Pointers wrap modulo DEPTH.

Decomposition:
- Package snn_io_pkg holds:
  - FSM state enum (2 bits): IDLE=0, ISSUE=1, WAIT_DONE=2, REPORT=3.
  - OVF_CNT_W=8.
  - Default parameter constants.
- Sub-module spike_frame_fifo(WIDTH, DEPTH) contains the storage, pointers, count and the overwrite mode.
- The existing synchronizer module is reused, generalised to SYNC_STAGES.

Test Plan:
1. FIFO path: reset; fifo_mode=1, snn_en=1; one frame 0xA5. Expect snn_spikes=0xA5 and a snn_step pulse. After that, snn_done with snn_out_spikes=0x3C gives out_spikes=0x3C and output_ready high for exactly 4 cycles.
2. Overflow: snn_en=0, push 6 frames 0x01..0x06 with DEPTH=4. Expect fifo_count=4 and overflow_cnt=2. Then enable: steps run in order 0x01..0x04.
3. Overwrite mode: fifo_mode=0, snn_en=0, frames 0x11, 0x22, 0x33. Expect fifo_count=1 and overflow_cnt=2. Enable: a single step with 0x33.
4. Timeout: TIMEOUT=10, snn_done is never asserted. REPORT is entered 10 cycles after WAIT_DONE; out_spikes=0, timeout_flag=1, output_ready pulses.
5. Mid-operation: deassert snn_en during WAIT_DONE with 2 frames queued. The current step completes and the FSM returns to IDLE with fifo_count=2. Reset asserted in WAIT_DONE: all outputs 0 within the same cycle.
6. Spurious completion: a snn_done pulse in IDLE causes no output_ready and no out_spikes change. Saturation: 300 dropped frames give overflow_cnt=255.
